// File: rtl/tx_symbol_scheduler_pkg.sv
// Shared types and code points for the transmit symbol scheduler.
// Also holds the legal control-code check used by the 8b/10b encoder.
package tx_sym_pkg;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_SKP    = 1'b1
  } state_t;

  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K28_0    = 8'h1C;
  localparam logic [7:0] IDLE_D00 = 8'h00;

  // Byte chosen by the scheduler, waiting one stage for encoding.
  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
    logic       k;
    logic       skp;
  } sel_t;

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
           (b == 8'hFD) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/tx_symbol_scheduler_encoder.sv
// Combinational 8b/10b encoder: chained 5b/6b and 3b/4b sub-blocks with running disparity.
// rd_in/rd_out use 1 = RD-; an illegal K code is flagged and encoded as data.
module encoder_8b10b
  import tx_sym_pkg::*;
(
  input  logic [7:0] data_byte,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] symbol,
  output logic       rd_out,
  output logic       k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok;
  logic       k28;
  logic       alt7;
  logic       flip6;
  logic       flip4;
  logic       rd6;
  logic [5:0] code6;
  logic [3:0] code4;
  logic [5:0] six;
  logic [3:0] four;

  assign x     = data_byte[4:0];
  assign y     = data_byte[7:5];
  assign k_ok  = k && is_legal_k(data_byte);
  assign k_err = k && !k_ok;
  assign k28   = k_ok && (x == 5'd28);

  // 5b/6b codes as seen from RD-; the RD+ form is the complement when flip6 is set.
  always_comb begin
    code6 = 6'b000000;
    case (x)
      5'd0:  code6 = 6'b100111;
      5'd1:  code6 = 6'b011101;
      5'd2:  code6 = 6'b101101;
      5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b110101;
      5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;
      5'd7:  code6 = 6'b111000;
      5'd8:  code6 = 6'b111001;
      5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;
      5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;
      5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;
      5'd15: code6 = 6'b010111;
      5'd16: code6 = 6'b011011;
      5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;
      5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;
      5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;
      5'd23: code6 = 6'b111010;
      5'd24: code6 = 6'b110011;
      5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;
      5'd27: code6 = 6'b110110;
      5'd28: code6 = k28 ? 6'b001111 : 6'b001110;
      5'd29: code6 = 6'b101110;
      5'd30: code6 = 6'b011110;
      5'd31: code6 = 6'b101011;
      default: code6 = 6'b000000;
    endcase
  end

  // D.7 is balanced yet still has distinct RD- and RD+ forms.
  assign flip6 = ($countones(code6) != 3) || (x == 5'd7);
  assign six   = (!rd_in && flip6) ? ~code6 : code6;
  assign rd6   = ($countones(code6) != 3) ? !rd_in : rd_in;

  assign alt7 = rd6 ? ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))
                    : ((x == 5'd11) || (x == 5'd13) || (x == 5'd14));

  always_comb begin
    code4 = 4'b0000;
    if (k_ok) begin
      case (y)
        3'd0: code4 = 4'b1011;
        3'd1: code4 = 4'b0110;
        3'd2: code4 = 4'b1010;
        3'd3: code4 = 4'b1100;
        3'd4: code4 = 4'b1101;
        3'd5: code4 = 4'b0101;
        3'd6: code4 = 4'b1001;
        3'd7: code4 = 4'b0111;
        default: code4 = 4'b0000;
      endcase
    end else begin
      case (y)
        3'd0: code4 = 4'b1011;
        3'd1: code4 = 4'b1001;
        3'd2: code4 = 4'b0101;
        3'd3: code4 = 4'b1100;
        3'd4: code4 = 4'b1101;
        3'd5: code4 = 4'b1010;
        3'd6: code4 = 4'b0110;
        3'd7: code4 = alt7 ? 4'b0111 : 4'b1110;
        default: code4 = 4'b0000;
      endcase
    end
  end

  // Every K sub-block swaps with disparity, including the balanced ones.
  assign flip4  = k_ok || (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
  assign four   = (!rd6 && flip4) ? ~code4 : code4;
  assign rd_out = ($countones(code4) != 2) ? !rd6 : rd6;
  assign symbol = {six, four};

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Per-cycle source selection (data / SKP ordered set / idle) followed by 8b/10b encoding.
// Two-stage pipeline: select register, then encoded output register owning running disparity.
module tx_symbol_scheduler
  import tx_sym_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_FORCE    = 1538,
  parameter int SKP_SYMS     = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  input  logic       data_k_i,
  output logic       data_ready_o,
  output logic [9:0] sym_o,
  output logic       sym_valid_o,
  output logic       rd_neg_o,
  output logic       skp_active_o,
  output logic       k_err_o
);

  localparam int CW = $clog2(SKP_FORCE + 1);
  localparam int SW = (SKP_SYMS > 1) ? $clog2(SKP_SYMS) : 1;
  localparam logic [CW-1:0] FORCE_C = CW'(SKP_FORCE);
  localparam logic [CW-1:0] INTV_C  = CW'(SKP_INTERVAL);
  localparam logic [SW-1:0] LAST_C  = SW'(SKP_SYMS - 1);

  state_t        state;
  logic [CW-1:0] skp_cnt;
  logic [SW-1:0] skp_sym_cnt;
  sel_t          sel_q;
  logic          force_skp;
  logic          pend_skp;
  logic          accept;
  logic [9:0]    enc_sym;
  logic          enc_rd;
  logic          enc_kerr;

  assign force_skp    = (skp_cnt >= FORCE_C);
  assign pend_skp     = (skp_cnt >= INTV_C);
  assign data_ready_o = !rst_i && (state == ST_STREAM) && !force_skp;
  assign accept       = data_valid_i && data_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_STREAM;
      skp_cnt     <= '0;
      skp_sym_cnt <= '0;
      sel_q       <= '0;
    end else begin
      sel_q.vld <= 1'b1;
      case (state)
        ST_STREAM: begin
          // Pending SKP only displaces idle; forced SKP also blocks data.
          if (force_skp || (!accept && pend_skp)) begin
            sel_q.dat   <= K28_5;
            sel_q.k     <= 1'b1;
            sel_q.skp   <= 1'b1;
            skp_cnt     <= '0;
            skp_sym_cnt <= '0;
            state       <= ST_SKP;
          end else begin
            sel_q.dat <= accept ? data_i : IDLE_D00;
            sel_q.k   <= accept && data_k_i;
            sel_q.skp <= 1'b0;
            if (skp_cnt != FORCE_C) begin
              skp_cnt <= skp_cnt + 1'b1;
            end
          end
        end
        ST_SKP: begin
          sel_q.dat <= K28_0;
          sel_q.k   <= 1'b1;
          sel_q.skp <= 1'b1;
          if (skp_sym_cnt == LAST_C) begin
            state <= ST_STREAM;
          end else begin
            skp_sym_cnt <= skp_sym_cnt + 1'b1;
          end
        end
        default: state <= ST_STREAM;
      endcase
    end
  end

  encoder_8b10b u_enc (
    .data_byte (sel_q.dat),
    .k         (sel_q.k),
    .rd_in     (rd_neg_o),
    .symbol    (enc_sym),
    .rd_out    (enc_rd),
    .k_err     (enc_kerr)
  );

  // rd_neg_o doubles as the lane's running-disparity register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sym_o        <= '0;
      sym_valid_o  <= 1'b0;
      rd_neg_o     <= 1'b1;
      skp_active_o <= 1'b0;
      k_err_o      <= 1'b0;
    end else if (sel_q.vld) begin
      sym_o        <= enc_sym;
      sym_valid_o  <= 1'b1;
      rd_neg_o     <= enc_rd;
      skp_active_o <= sel_q.skp;
      k_err_o      <= enc_kerr;
    end else begin
      sym_valid_o  <= 1'b0;
      k_err_o      <= 1'b0;
    end
  end

endmodule
